// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// State encoding, next-PC select codes and the default reset/exception vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_EXC
  } pc_sel_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEF_PC_STEP      = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_incr.sv
// Combinational PC incrementer; one adder feeds both PCPlus4 and the sequential next PC.
// Wraps modulo 2^32 with no carry out.
module pc_incr #(
  parameter int unsigned STEP = 4
) (
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_inc
);

  assign o_pc_inc = i_pc + 32'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC priority mux, fetch handshake FSM and EPC capture.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned branch/jump targets into exceptions.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned PC_STEP      = DEF_PC_STEP
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic        ExcReq,
  input  logic        IMemReady,
  output logic        IMemReq,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        MisalignFlag,
`endif
  output logic [31:0] EPC
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_misalign;

  pc_sel_t     w_sel;
  logic        w_active;
  logic        w_redirect;
  logic        w_misalign;
  logic        w_take_exc;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_next;
  logic [31:0] w_epc_next;

  pc_incr #(.STEP(PC_STEP)) u_incr (
    .i_pc     (r_pc),
    .o_pc_inc (w_pc_inc)
  );

  always_comb begin
    w_active   = (r_state != S_BOOT);
    w_redirect = w_active && (ExcReq || JumpTaken || BranchTaken);

    // Redirects outrank Stall; Stall outranks a completed fetch.
    w_sel = SEL_HOLD;
    if (w_active) begin
      if (ExcReq)                     w_sel = SEL_EXC;
      else if (JumpTaken)             w_sel = SEL_JMP;
      else if (BranchTaken)           w_sel = SEL_BR;
      else if (!Stall && IMemReady)   w_sel = SEL_INC;
    end

    w_target = (w_sel == SEL_JMP) ? JumpTarget : BranchTarget;

`ifdef PC_MISALIGN_TRAP_EN
    w_misalign = ((w_sel == SEL_JMP) || (w_sel == SEL_BR)) && is_misaligned(w_target);
`else
    w_misalign = 1'b0;
`endif

    w_take_exc = (w_sel == SEL_EXC) || w_misalign;
    w_epc_next = (w_sel == SEL_EXC) ? r_pc : w_target;

    case (w_sel)
      SEL_INC: w_pc_next = w_pc_inc;
      SEL_BR,
      SEL_JMP: w_pc_next = w_misalign ? EXC_VECTOR : w_target;
      SEL_EXC: w_pc_next = EXC_VECTOR;
      default: w_pc_next = r_pc;
    endcase

    // A redirect abandons the in-flight fetch, so no instruction is reported.
    IMemReq    = w_active && !Stall;
    InstrValid = IMemReq && IMemReady && !w_redirect;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_epc      <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign;
      if (w_take_exc) r_epc <= w_epc_next;
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        default: begin
          if (w_redirect)     r_state <= S_FETCH;
          else if (Stall)     r_state <= r_state;
          else if (IMemReady) r_state <= S_FETCH;
          else                r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign PC      = r_pc;
  assign PCPlus4 = w_pc_inc;
  assign EPC     = r_epc;

`ifdef PC_MISALIGN_TRAP_EN
  assign MisalignFlag = r_misalign;
`else
  logic w_unused;
  assign w_unused = r_misalign;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, fetch stalls, redirect priority, wrap, async reset, misalign.
// Honours PC_MISALIGN_TRAP_EN to pick the expected misaligned-jump behaviour.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic        ExcReq;
  logic        IMemReady;
  logic        IMemReq;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic [31:0] EPC;
`ifdef PC_MISALIGN_TRAP_EN
  logic        MisalignFlag;
`endif

  int vectors     = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .JumpTaken    (JumpTaken),
    .JumpTarget   (JumpTarget),
    .ExcReq       (ExcReq),
    .IMemReady    (IMemReady),
    .IMemReq      (IMemReq),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .InstrValid   (InstrValid),
`ifdef PC_MISALIGN_TRAP_EN
    .MisalignFlag (MisalignFlag),
`endif
    .EPC          (EPC)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_redirects();
    ExcReq = 1'b0; JumpTaken = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0; ExcReq = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; IMemReady = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    vectors++; if (EPC !== 32'h0) begin miscompares++; $display("FAIL reset_epc got %h want %h", EPC, 32'h0); end
    vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", IMemReq); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", InstrValid); end
    $display("reset: PC=%h EPC=%h IMemReq=%b InstrValid=%b", PC, EPC, IMemReq, InstrValid);
  endtask

  task automatic test_sequential();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL boot_req got %b want 0", IMemReq); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL boot_valid got %b want 0", InstrValid); end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (PC !== 32'(4 * k) || InstrValid !== 1'b1 || IMemReq !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_fetch[%0d] got PC=%h valid=%b req=%b want PC=%h valid=1 req=1", k, PC, InstrValid, IMemReq, 32'(4 * k));
      end
      $display("seq: PC=%h InstrValid=%b", PC, InstrValid);
    end
  endtask

  task automatic test_wait();
    step();
    IMemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (PC !== 32'h10 || IMemReq !== 1'b1 || InstrValid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_hold[%0d] got PC=%h req=%b valid=%b want PC=00000010 req=1 valid=0", i, PC, IMemReq, InstrValid);
      end
      $display("wait: PC=%h IMemReq=%b", PC, IMemReq);
      step();
    end
    IMemReady = 1'b1;
    #1;
    vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL wait_done_valid got %b want 1", InstrValid); end
    step();
    vectors++; if (PC !== 32'h14) begin miscompares++; $display("FAIL wait_next_pc got %h want %h", PC, 32'h14); end
    $display("wait done: PC=%h", PC);
  endtask

  task automatic test_stall_branch();
    repeat (3) step();
    vectors++; if (PC !== 32'h20) begin miscompares++; $display("FAIL reach_20 got %h want %h", PC, 32'h20); end
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h200;
    #1;
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL stall_br_valid got %b want 0", InstrValid); end
    step();
    clear_redirects();
    vectors++; if (PC !== 32'h200) begin miscompares++; $display("FAIL stall_br_pc got %h want %h", PC, 32'h200); end
    $display("stall+branch: PC=%h", PC);
    Stall = 1'b1;
    #1;
    vectors++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin miscompares++; $display("FAIL stall_outputs got req=%b valid=%b want 0 0", IMemReq, InstrValid); end
    repeat (2) step();
    vectors++; if (PC !== 32'h200) begin miscompares++; $display("FAIL stall_hold got %h want %h", PC, 32'h200); end
    clear_redirects();
    $display("stall: PC=%h", PC);
  endtask

  task automatic test_exc_priority();
    JumpTaken = 1'b1; JumpTarget = 32'h44;
    step();
    clear_redirects();
    vectors++; if (PC !== 32'h44) begin miscompares++; $display("FAIL jump_44 got %h want %h", PC, 32'h44); end
    ExcReq = 1'b1; JumpTaken = 1'b1; JumpTarget = 32'h400; BranchTaken = 1'b1; BranchTarget = 32'h300;
    #1;
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL exc_valid got %b want 0", InstrValid); end
    step();
    clear_redirects();
    vectors++; if (PC !== 32'h80) begin miscompares++; $display("FAIL exc_pc got %h want %h", PC, 32'h80); end
    vectors++; if (EPC !== 32'h44) begin miscompares++; $display("FAIL exc_epc got %h want %h", EPC, 32'h44); end
    $display("exc: PC=%h EPC=%h", PC, EPC);
    JumpTaken = 1'b1; BranchTaken = 1'b1;
    step();
    clear_redirects();
    vectors++; if (PC !== 32'h400 || EPC !== 32'h44) begin miscompares++; $display("FAIL jmp_over_br got PC=%h EPC=%h want 00000400 00000044", PC, EPC); end
    $display("jump>branch: PC=%h", PC);
    IMemReady = 1'b0; BranchTaken = 1'b1;
    step();
    clear_redirects();
    vectors++; if (PC !== 32'h300) begin miscompares++; $display("FAIL br_not_ready got %h want %h", PC, 32'h300); end
    IMemReady = 1'b1;
    $display("branch unready: PC=%h", PC);
  endtask

  task automatic test_wrap_async_reset();
    JumpTaken = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    vectors++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4 got PC=%h PCPlus4=%h want fffffffc 00000000", PC, PCPlus4); end
    step();
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want %h", PC, 32'h0); end
    step();
    IMemReady = 1'b0;
    step();
    vectors++; if (PC !== 32'h4 || IMemReq !== 1'b1) begin miscompares++; $display("FAIL wait_pre_reset got PC=%h req=%b want 00000004 1", PC, IMemReq); end
    #2 Reset = 1'b1;
    #1;
    vectors++; if (PC !== 32'h0 || IMemReq !== 1'b0 || EPC !== 32'h0) begin miscompares++; $display("FAIL async_reset got PC=%h req=%b EPC=%h want 0 0 0", PC, IMemReq, EPC); end
    $display("async reset: PC=%h IMemReq=%b EPC=%h", PC, IMemReq, EPC);
    @(negedge Clk);
    Reset = 1'b0; IMemReady = 1'b1;
    #1;
    vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL reboot_req got %b want 0", IMemReq); end
    step();
    vectors++; if (PC !== 32'h0 || InstrValid !== 1'b1) begin miscompares++; $display("FAIL reboot_fetch got PC=%h valid=%b want 00000000 1", PC, InstrValid); end
  endtask

  task automatic test_misalign();
    JumpTaken = 1'b1; JumpTarget = 32'h102;
    step();
    clear_redirects();
`ifdef PC_MISALIGN_TRAP_EN
    vectors++; if (PC !== 32'h80 || EPC !== 32'h102) begin miscompares++; $display("FAIL misalign_trap got PC=%h EPC=%h want 00000080 00000102", PC, EPC); end
    vectors++; if (MisalignFlag !== 1'b1) begin miscompares++; $display("FAIL misalign_flag got %b want 1", MisalignFlag); end
    step();
    vectors++; if (MisalignFlag !== 1'b0 || PC !== 32'h84) begin miscompares++; $display("FAIL misalign_pulse got flag=%b PC=%h want 0 00000084", MisalignFlag, PC); end
`else
    vectors++; if (PC !== 32'h102 || EPC !== 32'h0) begin miscompares++; $display("FAIL misalign_load got PC=%h EPC=%h want 00000102 00000000", PC, EPC); end
`endif
    $display("misaligned jump: PC=%h EPC=%h", PC, EPC);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall_branch();
    test_exc_priority();
    test_wrap_async_reset();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
